// File: rtl/seg7_para_bcd.sv
// Purpose: recover a 4-digit BCD frame from a multiplexed active-low 7-segment bus via a stability filter.
// Latency: slot written on the ESTAVEL-th identical sample edge; digitos/valido update one edge after the last slot write.
// Backpressure: none on the bus; an unread frame is overwritten and flagged via sobrescrito.
module seg7_para_bcd #(
    parameter int unsigned ESTAVEL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  display,
    input  logic [3:0]  anodo,
    input  logic        ler,
    output logic [15:0] digitos,
    output logic        valido,
    output logic        erro,
    output logic        sobrescrito
);

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        CONTANDO = 2'd1,
        GRAVADO  = 2'd2
    } estado_t;

    localparam logic [7:0] ALVO = 8'(ESTAVEL);

    estado_t     estado_q, estado_d;
    logic [10:0] amostra_q, amostra_d;
    logic [7:0]  cont_q, cont_d;
    logic [15:0] slot_q, slot_d;
    logic [3:0]  capt_q, capt_d;
    logic [15:0] digitos_q, digitos_d;
    logic        valido_q, valido_d;
    logic        erro_q, erro_d;
    logic        sobr_q, sobr_d;

    logic [10:0] amostra;
    logic        muda;
    logic        grava;
    logic        sel_ok;
    logic [1:0]  indice;
    logic [3:0]  valor;
    logic        completo;
    logic [7:0]  cont_inc;

    // Segment pattern (g..a, active-low) to BCD; anything unrecognised is 4'hF.
    function automatic logic [3:0] decodifica(input logic [6:0] seg);
        logic [3:0] r;
        case (seg)
            7'b1000000: r = 4'd0;
            7'b1111001: r = 4'd1;
            7'b0100100: r = 4'd2;
            7'b0110000: r = 4'd3;
            7'b0011001: r = 4'd4;
            7'b0010010: r = 4'd5;
            7'b0000010: r = 4'd6;
            7'b1111000: r = 4'd7;
            7'b0000000: r = 4'd8;
            7'b0010000: r = 4'd9;
            default:    r = 4'hF;
        endcase
        return r;
    endfunction

    // Digit select: a write is only allowed when exactly one anode line is low.
    always_comb begin
        sel_ok = 1'b1;
        indice = 2'd0;
        case (anodo)
            4'b1110: indice = 2'd0;
            4'b1101: indice = 2'd1;
            4'b1011: indice = 2'd2;
            4'b0111: indice = 2'd3;
            default: sel_ok = 1'b0;
        endcase
    end

    // Stability filter; ESPERA forces the first post-reset sample to count as a change.
    always_comb begin
        amostra   = {anodo, display};
        muda      = (estado_q == ESPERA) || (amostra != amostra_q);
        cont_inc  = cont_q + 8'd1;
        estado_d  = estado_q;
        amostra_d = amostra_q;
        cont_d    = cont_q;
        grava     = 1'b0;
        if (muda) begin
            amostra_d = amostra;
            cont_d    = 8'd1;
            estado_d  = CONTANDO;
        end else if (estado_q == CONTANDO) begin
            cont_d = cont_inc;
            if (cont_inc == ALVO) begin
                estado_d = GRAVADO;
                grava    = sel_ok;
            end
        end
    end

    // Slot capture and frame hand-off; a completing frame clears captured bits before this edge's write lands.
    always_comb begin
        valor     = decodifica(display);
        completo  = &capt_q;
        slot_d    = slot_q;
        capt_d    = completo ? 4'b0000 : capt_q;
        digitos_d = digitos_q;
        valido_d  = valido_q;
        erro_d    = erro_q;
        sobr_d    = sobr_q;
        if (grava) begin
            slot_d[{indice, 2'b00} +: 4] = valor;
            capt_d = capt_d | (4'b0001 << indice);
            if (valor == 4'hF) begin
                erro_d = 1'b1;
            end
        end
        if (completo) begin
            digitos_d = slot_q;
            valido_d  = 1'b1;
            if (valido_q && !ler) begin
                sobr_d = 1'b1;
            end
        end else if (ler && valido_q) begin
            valido_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= ESPERA;
            amostra_q <= '1;
            cont_q    <= 8'd0;
            slot_q    <= 16'hFFFF;
            capt_q    <= 4'b0000;
            digitos_q <= 16'hFFFF;
            valido_q  <= 1'b0;
            erro_q    <= 1'b0;
            sobr_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            amostra_q <= amostra_d;
            cont_q    <= cont_d;
            slot_q    <= slot_d;
            capt_q    <= capt_d;
            digitos_q <= digitos_d;
            valido_q  <= valido_d;
            erro_q    <= erro_d;
            sobr_q    <= sobr_d;
        end
    end

    assign digitos     = digitos_q;
    assign valido      = valido_q;
    assign erro        = erro_q;
    assign sobrescrito = sobr_q;

endmodule

// File: tb/tb_seg7_para_bcd.sv
// Directed table-driven bench for seg7_para_bcd with ESTAVEL=4.
// Each row drives inputs for N edges, then checks outputs and internal capture state.
// Reset rows are part of the table so mid-frame/mid-count resets run in sequence.
module tb_seg7_para_bcd;

    logic        clk;
    logic        reset;
    logic [6:0]  display;
    logic [3:0]  anodo;
    logic        ler;
    logic [15:0] digitos;
    logic        valido;
    logic        erro;
    logic        sobrescrito;

    int n_vec = 0;
    int n_err = 0;

    seg7_para_bcd #(.ESTAVEL(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .display     (display),
        .anodo       (anodo),
        .ler         (ler),
        .digitos     (digitos),
        .valido      (valido),
        .erro        (erro),
        .sobrescrito (sobrescrito)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [3:0] A0 = 4'b1110;
    localparam logic [3:0] A1 = 4'b1101;
    localparam logic [3:0] A2 = 4'b1011;
    localparam logic [3:0] A3 = 4'b0111;
    localparam logic [3:0] AX = 4'b1111;

    typedef struct {
        logic        rst;
        logic [3:0]  an;
        logic [6:0]  dp;
        logic        rd;
        int          n;
        logic [15:0] dig;
        logic        v;
        logic        e;
        logic        s;
        logic [3:0]  capt;
        int          sidx;   // 0 = no slot check, else slot index + 1
        logic [3:0]  sval;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(logic rst, logic [3:0] an, logic [6:0] dp, logic rd, int n,
                                logic [15:0] dig, logic v, logic e, logic s, logic [3:0] capt,
                                int sidx, logic [3:0] sval);
        vec_t t;
        t.rst = rst; t.an = an; t.dp = dp; t.rd = rd; t.n = n;
        t.dig = dig; t.v = v; t.e = e; t.s = s; t.capt = capt;
        t.sidx = sidx; t.sval = sval;
        return t;
    endfunction

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] slots;
        reset = 1'b1; anodo = AX; display = BL; ler = 1'b0;

        //           rst an  dp  rd  n   digitos   v  e  s  capt     sidx sval
        // reset state
        tab.push_back(mk(1, AX, BL, 0, 2, 16'hFFFF, 0, 0, 0, 4'b0000, 0, 4'h0));
        // slot0 written on 4th edge, then held without rewrite
        tab.push_back(mk(0, A0, P0, 0, 3, 16'hFFFF, 0, 0, 0, 4'b0000, 0, 4'h0));
        tab.push_back(mk(0, A0, P0, 0, 1, 16'hFFFF, 0, 0, 0, 4'b0001, 1, 4'h0));
        tab.push_back(mk(0, A0, P0, 0, 3, 16'hFFFF, 0, 0, 0, 4'b0001, 1, 4'h0));
        // overwrite slot0, then build 1,2,5,9
        tab.push_back(mk(0, A0, P9, 0, 4, 16'hFFFF, 0, 0, 0, 4'b0001, 1, 4'h9));
        tab.push_back(mk(0, A3, P1, 0, 4, 16'hFFFF, 0, 0, 0, 4'b1001, 4, 4'h1));
        tab.push_back(mk(0, A2, P2, 0, 4, 16'hFFFF, 0, 0, 0, 4'b1101, 0, 4'h0));
        tab.push_back(mk(0, A1, P5, 0, 3, 16'hFFFF, 0, 0, 0, 4'b1101, 0, 4'h0));
        tab.push_back(mk(0, A1, P5, 0, 1, 16'hFFFF, 0, 0, 0, 4'b1111, 2, 4'h5));
        tab.push_back(mk(0, A1, P5, 0, 1, 16'h1259, 1, 0, 0, 4'b0000, 0, 4'h0));
        tab.push_back(mk(0, A1, P5, 0, 3, 16'h1259, 1, 0, 0, 4'b0000, 0, 4'h0));
        // acknowledge, then ack with nothing pending
        tab.push_back(mk(0, A1, P5, 1, 1, 16'h1259, 0, 0, 0, 4'b0000, 0, 4'h0));
        tab.push_back(mk(0, A1, P5, 1, 1, 16'h1259, 0, 0, 0, 4'b0000, 0, 4'h0));
        // short run (3 edges) then change: no write
        tab.push_back(mk(0, A2, P2, 0, 3, 16'h1259, 0, 0, 0, 4'b0000, 0, 4'h0));
        tab.push_back(mk(0, AX, BL, 0, 5, 16'h1259, 0, 0, 0, 4'b0000, 0, 4'h0));
        // two anodes low: no write; blank on digit 3: F and erro
        tab.push_back(mk(0, 4'b1100, P0, 0, 10, 16'h1259, 0, 0, 0, 4'b0000, 0, 4'h0));
        tab.push_back(mk(0, A3, BL, 0, 4, 16'h1259, 0, 1, 0, 4'b1000, 4, 4'hF));
        // first frame F210, no ack
        tab.push_back(mk(0, A0, P0, 0, 4, 16'h1259, 0, 1, 0, 4'b1001, 0, 4'h0));
        tab.push_back(mk(0, A1, P1, 0, 4, 16'h1259, 0, 1, 0, 4'b1011, 0, 4'h0));
        tab.push_back(mk(0, A2, P2, 0, 5, 16'hF210, 1, 1, 0, 4'b0000, 0, 4'h0));
        // second frame 9521 overwrites unread frame
        tab.push_back(mk(0, A3, P9, 0, 4, 16'hF210, 1, 1, 0, 4'b1000, 0, 4'h0));
        tab.push_back(mk(0, A2, P5, 0, 4, 16'hF210, 1, 1, 0, 4'b1100, 0, 4'h0));
        tab.push_back(mk(0, A1, P2, 0, 4, 16'hF210, 1, 1, 0, 4'b1110, 0, 4'h0));
        tab.push_back(mk(0, A0, P1, 0, 5, 16'h9521, 1, 1, 1, 4'b0000, 0, 4'h0));
        tab.push_back(mk(0, A0, P1, 1, 1, 16'h9521, 0, 1, 1, 4'b0000, 0, 4'h0));
        // reset clears sticky flags; reset after 2 captured slots
        tab.push_back(mk(1, A0, P1, 0, 1, 16'hFFFF, 0, 0, 0, 4'b0000, 0, 4'h0));
        tab.push_back(mk(0, A3, P1, 0, 4, 16'hFFFF, 0, 0, 0, 4'b1000, 0, 4'h0));
        tab.push_back(mk(0, A2, P2, 0, 4, 16'hFFFF, 0, 0, 0, 4'b1100, 0, 4'h0));
        tab.push_back(mk(1, A2, P2, 0, 1, 16'hFFFF, 0, 0, 0, 4'b0000, 4, 4'hF));
        // same input after reset still needs a full run
        tab.push_back(mk(0, A2, P2, 0, 3, 16'hFFFF, 0, 0, 0, 4'b0000, 0, 4'h0));
        tab.push_back(mk(0, A2, P2, 0, 1, 16'hFFFF, 0, 0, 0, 4'b0100, 0, 4'h0));
        tab.push_back(mk(0, A1, P5, 0, 4, 16'hFFFF, 0, 0, 0, 4'b0110, 0, 4'h0));
        tab.push_back(mk(0, A1, P5, 0, 2, 16'hFFFF, 0, 0, 0, 4'b0110, 0, 4'h0));
        // mid-count reset
        tab.push_back(mk(0, A0, P9, 0, 2, 16'hFFFF, 0, 0, 0, 4'b0110, 0, 4'h0));
        tab.push_back(mk(1, A0, P9, 0, 1, 16'hFFFF, 0, 0, 0, 4'b0000, 3, 4'hF));
        tab.push_back(mk(0, A0, P9, 0, 3, 16'hFFFF, 0, 0, 0, 4'b0000, 0, 4'h0));
        tab.push_back(mk(0, A0, P9, 0, 1, 16'hFFFF, 0, 0, 0, 4'b0001, 0, 4'h0));
        tab.push_back(mk(0, A3, P1, 0, 4, 16'hFFFF, 0, 0, 0, 4'b1001, 0, 4'h0));
        tab.push_back(mk(0, A2, P2, 0, 4, 16'hFFFF, 0, 0, 0, 4'b1101, 0, 4'h0));
        tab.push_back(mk(0, A1, P5, 0, 5, 16'h1259, 1, 0, 0, 4'b0000, 0, 4'h0));
        // next frame completes on the same edge as ler: no overwrite flag
        tab.push_back(mk(0, A3, P9, 0, 4, 16'h1259, 1, 0, 0, 4'b1000, 0, 4'h0));
        tab.push_back(mk(0, A2, P5, 0, 4, 16'h1259, 1, 0, 0, 4'b1100, 0, 4'h0));
        tab.push_back(mk(0, A1, P2, 0, 4, 16'h1259, 1, 0, 0, 4'b1110, 0, 4'h0));
        tab.push_back(mk(0, A0, P1, 0, 4, 16'h1259, 1, 0, 0, 4'b1111, 0, 4'h0));
        tab.push_back(mk(0, A0, P1, 1, 1, 16'h9521, 1, 0, 0, 4'b0000, 0, 4'h0));
        tab.push_back(mk(0, A0, P1, 1, 1, 16'h9521, 0, 0, 0, 4'b0000, 0, 4'h0));
        tab.push_back(mk(0, A0, P1, 0, 1, 16'h9521, 0, 0, 0, 4'b0000, 0, 4'h0));

        for (int r = 0; r < tab.size(); r++) begin
            reset   = tab[r].rst;
            anodo   = tab[r].an;
            display = tab[r].dp;
            ler     = tab[r].rd;
            for (int k = 0; k < tab[r].n; k++) step();
            reset = 1'b0;
            chk("digitos",     r, digitos,               tab[r].dig);
            chk("valido",      r, {15'd0, valido},       {15'd0, tab[r].v});
            chk("erro",        r, {15'd0, erro},         {15'd0, tab[r].e});
            chk("sobrescrito", r, {15'd0, sobrescrito},  {15'd0, tab[r].s});
            chk("captured",    r, {12'd0, dut.capt_q},   {12'd0, tab[r].capt});
            if (tab[r].sidx != 0) begin
                slots = dut.slot_q;
                chk("slot", r, {12'd0, slots[(tab[r].sidx - 1) * 4 +: 4]}, {12'd0, tab[r].sval});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
